cd_bus_timer: RTL

CD_BUS_TIMER -- requirements
Module: cd_bus_timer

---
 rtl/cd_bus_timer_pkg.sv | 13 +
 rtl/cd_bus_timer_idle_cnt.sv | 37 +++
 rtl/cd_bus_timer.sv | 100 ++++++++++
 3 files changed

// File: rtl/cd_bus_timer_pkg.sv
// Shared definitions for the CD bus timer: FSM state encoding and counter width.
package cd_bus_timer_pkg;

  localparam int CD_CNT_W = 10;

  typedef enum logic [1:0] {
    ST_BUSY      = 2'd0,
    ST_WAIT_IDLE = 2'd1,
    ST_IDLE      = 2'd2,
    ST_PERMIT    = 2'd3
  } cd_state_e;

endpackage

// File: rtl/cd_bus_timer_idle_cnt.sv
// Saturating idle-bit counter. A clear always beats a coincident tick.
// cnt_nxt exposes the value the counter takes at the next edge so the FSM
// can act in the same cycle as the tick that crosses a threshold.
module cd_idle_cnt
  import cd_bus_timer_pkg::*;
#(
  parameter int CNT_W = CD_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             tick,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // next count: clear, else saturating increment on tick
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (tick && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  // count register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt     = cnt_q;
  assign cnt_nxt = cnt_d;

endmodule

// File: rtl/cd_bus_timer.sv
// CD bus timer: tracks idle bit times on the bus, flags end of frame,
// bus idle, and grants permission to start a transmission.
module cd_bus_timer
  import cd_bus_timer_pkg::*;
#(
  parameter int CNT_W = CD_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             bit_tick,
  input  logic             rx,
  input  logic [7:0]       idle_wait_len,
  input  logic [9:0]       tx_permit_len,
  input  logic [9:0]       max_idle_len,
  input  logic             arbitration,
  input  logic             full_duplex,
  input  logic             tx_pending,
  input  logic             tx_active,
  output logic             bus_idle,
  output logic             tx_permit,
  output logic             frame_end,
  output logic [CNT_W-1:0] idle_cnt
);

  cd_state_e        state_q, state_d;
  logic             bus_idle_q, bus_idle_d;
  logic             tx_permit_q, tx_permit_d;
  logic             frame_end_q, frame_end_d;
  logic             rx_low, cnt_clr;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [31:0]      cnt_w, thr_w;
  logic             wait_hit, permit_hit;

  // In full duplex our own receive level says nothing about the bus, so rx
  // is treated as permanently recessive.
  assign rx_low  = ~rx & ~full_duplex;
  assign cnt_clr = rx_low | tx_active;

  cd_idle_cnt #(.CNT_W(CNT_W)) u_idle_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .tick    (bit_tick),
    .cnt     (cnt),
    .cnt_nxt (cnt_nxt)
  );

  // Thresholds compare against the upcoming count so a state change lands
  // on the same edge the count reaches its threshold; a zero length is met
  // without any tick. Lengths are used live, never latched.
  always_comb begin
    cnt_w      = 32'(cnt_nxt);
    thr_w      = arbitration ? 32'(tx_permit_len) : 32'(idle_wait_len);
    wait_hit   = cnt_w >= 32'(idle_wait_len);
    permit_hit = (cnt_w >= thr_w) || (cnt_w >= 32'(max_idle_len));
  end

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_BUSY;
    else          state_q <= state_d;
  end

  // next state and registered-output inputs
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BUSY:      if (!cnt_clr) state_d = ST_WAIT_IDLE;
      ST_WAIT_IDLE: if (cnt_clr) state_d = ST_BUSY;
                    else if (wait_hit) state_d = ST_IDLE;
      ST_IDLE:      if (cnt_clr) state_d = ST_BUSY;
                    else if (tx_pending && permit_hit) state_d = ST_PERMIT;
      ST_PERMIT:    if (rx_low || tx_active) state_d = ST_BUSY;
                    else if (!tx_pending) state_d = ST_IDLE;
      default:      state_d = ST_BUSY;
    endcase
    bus_idle_d  = (state_d == ST_IDLE) || (state_d == ST_PERMIT);
    frame_end_d = (state_q == ST_WAIT_IDLE) && (state_d == ST_IDLE);
    tx_permit_d = full_duplex ? (tx_pending & ~tx_active) : (state_d == ST_PERMIT);
  end

  // output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_idle_q  <= 1'b0;
      tx_permit_q <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      bus_idle_q  <= bus_idle_d;
      tx_permit_q <= tx_permit_d;
      frame_end_q <= frame_end_d;
    end
  end

  assign bus_idle  = bus_idle_q;
  assign tx_permit = tx_permit_q;
  assign frame_end = frame_end_q;
  assign idle_cnt  = cnt;

endmodule
